// File: rtl/tlb_entry_file.sv
// Joint TLB entry storage with TLBWI/TLBWR/TLBR/TLBP maintenance engine.
// Also owns the Random and Wired replacement registers.
module tlb_entry_file #(
  parameter int NUM_ENTRIES = 16,
  parameter int ENTRY_W = 71,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [IW-1:0]                  cmd_index,
  input  logic [ENTRY_W-1:0]             cmd_entry,
  input  logic                           wired_we,
  input  logic [IW-1:0]                  wired_wdata,
  output logic [IW-1:0]                  wired,
  output logic [IW-1:0]                  random,
  output logic                           resp_valid,
  output logic [IW-1:0]                  resp_index,
  output logic                           resp_miss,
  output logic [ENTRY_W-1:0]             resp_entry,
  output logic [NUM_ENTRIES*ENTRY_W-1:0] tlb_entries
);

  localparam int VHI = ENTRY_W - 1;
  localparam int VLO = ENTRY_W - 19;
  localparam logic [IW-1:0] TOP = IW'(NUM_ENTRIES - 1);

  localparam logic [1:0] OP_WI = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;
  localparam logic [1:0] OP_R  = 2'd2;
  localparam logic [1:0] OP_P  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    RESP
  } state_t;

  state_t state, state_n;

  logic [ENTRY_W-1:0] ent [NUM_ENTRIES];
  logic [VHI-VLO:0]   vpn2;
  logic [IW-1:0]      cnt;
  logic [IW-1:0]      random_n;
  logic               accept;
  logic               hit;
  logic               last;

  assign random_n = (random == wired) ? TOP : random - 1'b1;
  assign hit = (ent[cnt][VHI:VLO] == vpn2);
  assign last = (cnt == TOP);
  assign resp_valid = (state == RESP);

  always_comb begin
    state_n = state;
    cmd_ready = 1'b0;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept = cmd_valid;
        if (cmd_valid)
          state_n = (cmd_op == OP_P) ? PROBE : RESP;
      end
      PROBE: begin
        if (hit || last)
          state_n = RESP;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wired <= '0;
      random <= TOP;
      resp_index <= '0;
      resp_miss <= 1'b0;
      resp_entry <= '0;
      vpn2 <= '0;
      cnt <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
        ent[i] <= '0;
    end else begin
      state <= state_n;
      // A Wired write restarts Random regardless of the decrement.
      if (wired_we) begin
        wired <= wired_wdata;
        random <= TOP;
      end else begin
        random <= random_n;
      end
      if (accept) begin
        unique case (1'b1)
          cmd_op == OP_WI: begin
            ent[cmd_index] <= cmd_entry;
            resp_index <= cmd_index;
            resp_miss <= 1'b0;
          end
          cmd_op == OP_WR: begin
            ent[random] <= cmd_entry;
            resp_index <= random;
            resp_miss <= 1'b0;
          end
          cmd_op == OP_R: begin
            resp_entry <= ent[cmd_index];
            resp_index <= cmd_index;
            resp_miss <= 1'b0;
          end
          cmd_op == OP_P: begin
            vpn2 <= cmd_entry[VHI:VLO];
            cnt <= '0;
          end
          default: ;
        endcase
      end
      if (state == PROBE) begin
        if (hit) begin
          resp_index <= cnt;
          resp_miss <= 1'b0;
        end else if (last) begin
          resp_index <= '0;
          resp_miss <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_flat
    assign tlb_entries[gi*ENTRY_W +: ENTRY_W] = ent[gi];
  end

endmodule

// File: tb/tb_tlb_entry_file.sv
// Directed bench for tlb_entry_file: maintenance ops, probe latency,
// Random/Wired behaviour and mid-probe reset.
module tb_tlb_entry_file;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_index;
  logic [70:0]   cmd_entry;
  logic          wired_we;
  logic [3:0]    wired_wdata;
  logic [3:0]    wired;
  logic [3:0]    random;
  logic          resp_valid;
  logic [3:0]    resp_index;
  logic          resp_miss;
  logic [70:0]   resp_entry;
  logic [1135:0] tlb_entries;

  int errors = 0;
  int checks = 0;

  logic [70:0] e5;
  logic [70:0] e9;
  logic [70:0] ew;

  tlb_entry_file dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_index(cmd_index),
    .cmd_entry(cmd_entry),
    .wired_we(wired_we),
    .wired_wdata(wired_wdata),
    .wired(wired),
    .random(random),
    .resp_valid(resp_valid),
    .resp_index(resp_index),
    .resp_miss(resp_miss),
    .resp_entry(resp_entry),
    .tlb_entries(tlb_entries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (random !== 4'd15) begin
      errors++;
      $display("FAIL reset_random: got %0d want 15", random);
    end
    checks++;
    if (wired !== 4'd0) begin
      errors++;
      $display("FAIL reset_wired: got %0d want 0", wired);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_index !== 4'd0 ||
        resp_miss !== 1'b0 || resp_entry !== '0) begin
      errors++;
      $display("FAIL reset_resp: got v=%b i=%0d m=%b want 0,0,0",
               resp_valid, resp_index, resp_miss);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_random_seq();
    logic [3:0] exp;
    exp = 4'd15;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (random !== exp || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL random_seq[%0d]: got r=%0d v=%b want r=%0d v=0",
                 i, random, resp_valid, exp);
      end
      exp = (exp == 4'd0) ? 4'd15 : exp - 4'd1;
      step();
    end
    checks++;
    if (tlb_entries !== '0) begin
      errors++;
      $display("FAIL idle_entries: got nonzero want 0");
    end
  endtask

  task automatic test_tlbwi();
    e5 = {19'h12345, 51'd0, 1'b1};
    e9 = {19'h12345, 24'hABCDEF, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0};
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_index = 4'd5;
    cmd_entry = e5;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_index !== 4'd5) begin
      errors++;
      $display("FAIL tlbwi5_resp: got v=%b i=%0d want v=1 i=5",
               resp_valid, resp_index);
    end
    checks++;
    if (tlb_entries[5*71 +: 71] !== e5) begin
      errors++;
      $display("FAIL tlbwi5_data: got %h want %h",
               tlb_entries[5*71 +: 71], e5);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL tlbwi_pulse: got v=%b rdy=%b want v=0 rdy=1",
               resp_valid, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_index = 4'd9;
    cmd_entry = e9;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_index !== 4'd9 ||
        tlb_entries[9*71 +: 71] !== e9) begin
      errors++;
      $display("FAIL tlbwi9: got v=%b i=%0d d=%h want v=1 i=9 d=%h",
               resp_valid, resp_index, tlb_entries[9*71 +: 71], e9);
    end
    step();
  endtask

  task automatic test_tlbr();
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    cmd_index = 4'd9;
    cmd_entry = '0;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_index !== 4'd9 || resp_entry !== e9) begin
      errors++;
      $display("FAIL tlbr9: got v=%b i=%0d d=%h want v=1 i=9 d=%h",
               resp_valid, resp_index, resp_entry, e9);
    end
    step();
  endtask

  task automatic test_tlbp_dup();
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_entry = {19'h12345, 52'd0};
    step();
    cmd_valid = 1'b0;
    for (int n = 1; n < 7; n++) begin
      checks++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL tlbp_dup_scan[%0d]: got v=%b rdy=%b want 0,0",
                 n, resp_valid, cmd_ready);
      end
      step();
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_index !== 4'd5 || resp_miss !== 1'b0) begin
      errors++;
      $display("FAIL tlbp_dup_resp: got v=%b i=%0d m=%b want 1,5,0",
               resp_valid, resp_index, resp_miss);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0 || resp_index !== 4'd5) begin
      errors++;
      $display("FAIL tlbp_hold: got v=%b i=%0d want v=0 i=5",
               resp_valid, resp_index);
    end
  endtask

  task automatic test_tlbp_miss();
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_entry = {19'h7FFFF, 52'd0};
    step();
    cmd_valid = 1'b0;
    for (int n = 1; n < 17; n++) begin
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL tlbp_miss_scan[%0d]: got v=%b want 0", n, resp_valid);
      end
      step();
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_index !== 4'd0 || resp_miss !== 1'b1) begin
      errors++;
      $display("FAIL tlbp_miss_resp: got v=%b i=%0d m=%b want 1,0,1",
               resp_valid, resp_index, resp_miss);
    end
    step();
  endtask

  task automatic test_wired_tlbwr();
    int budget;
    logic [3:0] exp [4];
    exp[0] = 4'd14;
    exp[1] = 4'd13;
    exp[2] = 4'd12;
    exp[3] = 4'd15;
    ew = {19'h0ABCD, 24'h111111, 1'b0, 1'b1, 24'h222222, 1'b1, 1'b0};
    do_reset();
    budget = 40;
    while (random !== 4'd3 && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (random !== 4'd3) begin
      errors++;
      $display("FAIL wired_wait: got random=%0d want 3 (timeout)", random);
    end
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    cmd_entry = ew;
    wired_we = 1'b1;
    wired_wdata = 4'd12;
    step();
    cmd_valid = 1'b0;
    wired_we = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_index !== 4'd3 ||
        tlb_entries[3*71 +: 71] !== ew) begin
      errors++;
      $display("FAIL tlbwr: got v=%b i=%0d d=%h want v=1 i=3 d=%h",
               resp_valid, resp_index, tlb_entries[3*71 +: 71], ew);
    end
    checks++;
    if (random !== 4'd15 || wired !== 4'd12) begin
      errors++;
      $display("FAIL wired_write: got r=%0d w=%0d want r=15 w=12",
               random, wired);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (random !== exp[i]) begin
        errors++;
        $display("FAIL wired_seq[%0d]: got %0d want %0d", i, random, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midprobe();
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_index = 4'd2;
    cmd_entry = {19'h00001, 52'd7};
    step();
    cmd_valid = 1'b0;
    step();
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_entry = {19'h55555, 52'd0};
    step();
    cmd_valid = 1'b0;
    for (int n = 1; n < 7; n++)
      step();
    checks++;
    if (cmd_ready !== 1'b0 || tlb_entries === '0) begin
      errors++;
      $display("FAIL midprobe_pre: got rdy=%b want 0 with entries nonzero",
               cmd_ready);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1 || resp_valid !== 1'b0 ||
        random !== 4'd15 || wired !== 4'd0) begin
      errors++;
      $display("FAIL midprobe_rst: got rdy=%b v=%b r=%0d w=%0d want 1,0,15,0",
               cmd_ready, resp_valid, random, wired);
    end
    checks++;
    if (tlb_entries !== '0 || resp_index !== 4'd0 || resp_miss !== 1'b0) begin
      errors++;
      $display("FAIL midprobe_clear: got i=%0d m=%b want entries=0 i=0 m=0",
               resp_index, resp_miss);
    end
    for (int n = 0; n < 12; n++) begin
      step();
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midprobe_quiet[%0d]: got v=1 want 0", n);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_index = 4'd0;
    cmd_entry = '0;
    wired_we = 1'b0;
    wired_wdata = 4'd0;
    test_reset();
    test_random_seq();
    test_tlbwi();
    test_tlbr();
    test_tlbp_dup();
    test_tlbp_miss();
    test_wired_tlbwr();
    test_reset_midprobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_entry_file.md
Name: tlb_entry_file

Overview:
- Storage and maintenance stage for the 16-entry joint TLB.
- Holds the entries and drives them, flattened, into the downstream combinational translation lookup.
- Executes the CP0 TLB instructions TLBWI, TLBWR, TLBR and TLBP through a valid/ready command port.
- Maintains the Random and Wired registers.

Parameters:
- NUM_ENTRIES, 16, number of TLB entries; the index width is fixed at 4 bits for this default.
- ENTRY_W, 71, packed entry width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
- cmd_op  in  2  0=TLBWI, 1=TLBWR, 2=TLBR, 3=TLBP.
- cmd_index  in  4  target index for TLBWI and TLBR.
- cmd_entry  in  71  write data for TLBWI/TLBWR; TLBP uses only [70:52].
- wired_we  in  1  write strobe for the Wired register.
- wired_wdata  in  4  new Wired value.
- wired  out  4  current Wired value.
- random  out  4  current Random value.
- resp_valid  out  1  one-cycle completion pulse.
- resp_index  out  4  index written, read or probed.
- resp_miss  out  1  TLBP found no match; valid only with resp_valid.
- resp_entry  out  71  TLBR read data; valid only with resp_valid.
- tlb_entries  out  1136  entry i occupies bits [71*i+70 : 71*i].

Behaviour:
- Entry format: [70:52] VPN2, [51:28] PFN1, [27] D1, [26] V1, [25:2] PFN0, [1] D0, [0] V0.
- Reset, applied at any time including mid-probe:
  - all entries cleared to 0;
  - wired=0, random=15;
  - FSM goes to IDLE;
  - resp_valid=0, resp_index=0, resp_miss=0, resp_entry=0.
- FSM states: IDLE, PROBE, RESP. cmd_ready=1 only in IDLE.
- IDLE, on an accepted command:
  - TLBWI: entry[cmd_index] <= cmd_entry at the accept edge; go to RESP with resp_index=cmd_index.
  - TLBWR: entry[random] <= cmd_entry, using the random value before this edge's update; go to RESP with resp_index equal to that value.
  - TLBR: go to RESP with resp_entry=entry[cmd_index] and resp_index=cmd_index.
  - TLBP: latch VPN2 from cmd_entry[70:52], set scan counter=0, go to PROBE.
- PROBE:
  - Each cycle compare entry[cnt][70:52] with the latched VPN2. Valid bits are ignored.
  - On match: go to RESP with resp_index=cnt, resp_miss=0.
  - On no match with cnt==15: go to RESP with resp_index=0, resp_miss=1.
  - Otherwise cnt++.
  - Duplicate VPN2 entries: the lowest index wins.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. resp_* fields hold their values until the next response.
- Latency, measured from the accept edge:
  - resp_valid is high in the cycle after accept for TLBWI, TLBWR and TLBR.
  - TLBP matching at entry k: resp_valid in cycle k+2.
  - TLBP miss: resp_valid in cycle 17.
- tlb_entries reflects a write in the cycle after the write edge.
- Random, updated every cycle:
  - random_next = (random == wired) ? 15 : random-1.
  - wired=0 gives a 15..0 cycle; wired=15 holds random at 15.
- Wired write:
  - wired_we: wired <= wired_wdata and random <= 15 at the same edge. This overrides the decrement.
  - A TLBWR accepted at the same edge uses the old random.
  - wired_we is accepted in any FSM state.
- cmd_valid outside IDLE is ignored. The command is not dropped by the requester; it must hold cmd_valid until accepted.

Test Plan:
- Reset, then idle 20 cycles with wired=0 -> random sequence 15,14,...,0,15; all tlb_entries = 0; resp_valid never asserted.
- TLBWI with index 5 and entry VPN2=0x12345, V0=1 -> resp_valid the next cycle with resp_index=5; tlb_entries[5*71+70 : 5*71] equals the written value.
- TLBP with VPN2=0x12345 after entries 5 and 9 are both written with it -> resp_valid at accept+7, resp_index=5, resp_miss=0; cmd_ready=0 during the scan.
- TLBP with VPN2=0x7FFFF on a fresh table -> resp_valid at accept+17, resp_miss=1, resp_index=0.
- wired_we=1 with wired_wdata=12 in the same cycle as an accepted TLBWR while random=3 -> entry 3 written; random then runs 15,14,13,12,15.
- Reset asserted mid-probe at cnt=6 -> next cycle: cmd_ready=1, resp_valid=0, entries cleared, random=15, wired=0.
